// File: rtl/regfile_sb.sv
// regfile_sb: parametrised multi-port register file with RAW scoreboard.
// NUM_RD combinational read ports, one write-back port, one issue port.
// A per-register busy bit marks destinations that are in flight. busy_cnt
// tracks how many registers are pending. After reset the array is cleared by
// a sweep that covers one register per cycle. Register 0 is hardwired to zero.
// Optional feature: define RF_BYPASS_EN to forward write-back data and busy
// clears to the read ports in the same cycle.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ready,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          addr_w,
    input  logic [DATA_W-1:0]          data_w,
    input  logic                       iss_valid,
    input  logic [ADDR_W-1:0]          iss_addr,
    input  logic [NUM_RD*ADDR_W-1:0]   addr_r,
    output logic [NUM_RD*DATA_W-1:0]   data_r,
    output logic [NUM_RD-1:0]          busy_r,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DEPTH-1:0]    busy_q, busy_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic                wr_ok, iss_ok, cnt_inc, cnt_dec;

    // Next-state for the sweep FSM, scoreboard and pending count; array write port select.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        wr_ok     = 1'b0;
        iss_ok    = 1'b0;
        cnt_inc   = 1'b0;
        cnt_dec   = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                // Clear one register per cycle; the edge that clears the last one enters RUN.
                mem_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                wr_ok  = we && (addr_w != '0);
                iss_ok = iss_valid && (iss_addr != '0);
                if (wr_ok) begin
                    mem_we    = 1'b1;
                    mem_waddr = addr_w;
                    mem_wdata = data_w;
                    busy_d[addr_w] = 1'b0;
                end
                // Issue is applied after the clear so it wins on a shared address.
                if (iss_ok) begin
                    busy_d[iss_addr] = 1'b1;
                end
                cnt_inc = iss_ok && !busy_q[iss_addr];
                cnt_dec = wr_ok && busy_q[addr_w] && !(iss_ok && (iss_addr == addr_w));
                cnt_d   = cnt_q + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};
            end
            default: ;
        endcase
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            state_q <= ST_INIT;
            ptr_q   <= ADDR_W'(1);
            busy_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    // Register array write port, shared by the clear sweep and write-back.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch; it is cleared by the sweep so it maps to plain RAM/flops.
        if (rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Combinational read ports; outputs forced to zero until the sweep is done.
    always_comb begin
        data_r = '0;
        busy_r = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] a;
            a = addr_r[k*ADDR_W +: ADDR_W];
            if (state_q == ST_RUN && a != '0) begin
                data_r[k*DATA_W +: DATA_W] = mem_q[a];
                busy_r[k]                  = busy_q[a];
`ifdef RF_BYPASS_EN
                if (we && addr_w == a) begin
                    data_r[k*DATA_W +: DATA_W] = data_w;
                    busy_r[k]                  = iss_valid && (iss_addr == addr_w);
                end
`endif
            end
        end
    end

    assign ready    = (state_q == ST_RUN);
    assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (DATA_W=32, ADDR_W=5, NUM_RD=2).
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic        we;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic [9:0]  addr_r;
    logic [63:0] data_r;
    logic [1:0]  busy_r;
    logic [5:0]  busy_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .we        (we),
        .addr_w    (addr_w),
        .data_w    (data_w),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .addr_r    (addr_r),
        .data_r    (data_r),
        .busy_r    (busy_r),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        addr_r = {a1, a0};
        #1;
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; addr_w = '0; data_w = '0;
        iss_valid = 1'b0; iss_addr = '0; addr_r = '0;

        // Reset, then sweep with write/issue traffic that must be ignored.
        step(); step();
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_cnt", 64'(busy_cnt), 64'd0);
        rst = 1'b1;
        we = 1'b1; addr_w = 5'd2; data_w = 32'h55; iss_valid = 1'b1; iss_addr = 5'd2;
        rd(5'd2, 5'd0);
        check("init_ready", 64'(ready), 64'd0);
        check("init_data_forced", data_r, 64'd0);
        repeat (30) step();
        check("sweep30_ready", 64'(ready), 64'd0);
        we = 1'b0; iss_valid = 1'b0;
        step();
        check("sweep31_ready", 64'(ready), 64'd1);
        rd(5'd2, 5'd0);
        check("init_wr_ignored", data_r, 64'd0);
        check("init_iss_cnt", 64'(busy_cnt), 64'd0);
        check("init_iss_busy", 64'(busy_r), 64'd0);

        // Write/read, including an attempted write to register 0.
        we = 1'b1; addr_w = 5'd7; data_w = 32'h12345678; step();
        addr_w = 5'd0; data_w = 32'hFFFFFFFF; step();
        we = 1'b0;
        rd(5'd7, 5'd0);
        check("rd_port0_r7", 64'(data_r[31:0]), 64'h12345678);
        check("rd_port1_r0", 64'(data_r[63:32]), 64'h0);

        // Preload reg5, hold reset 2 cycles, sweep must clear it.
        we = 1'b1; addr_w = 5'd5; data_w = 32'hDEAD; step();
        we = 1'b0;
        rd(5'd5, 5'd7);
        check("preload_r5", 64'(data_r[31:0]), 64'hDEAD);
        rst = 1'b0; step(); step();
        rst = 1'b1;
        repeat (30) step();
        check("sweep2_30_ready", 64'(ready), 64'd0);
        step();
        check("sweep2_31_ready", 64'(ready), 64'd1);
        rd(5'd5, 5'd7);
        check("swept_r5", 64'(data_r[31:0]), 64'h0);
        check("swept_r7", 64'(data_r[63:32]), 64'h0);
        check("swept_cnt", 64'(busy_cnt), 64'd0);

        // Scoreboard: issue 3, 4, 3.
        iss_valid = 1'b1; iss_addr = 5'd3; step();
        iss_addr = 5'd4; step();
        iss_addr = 5'd3; step();
        iss_valid = 1'b0;
        rd(5'd3, 5'd4);
        check("sb_cnt2", 64'(busy_cnt), 64'd2);
        check("sb_busy34", 64'(busy_r), 64'b11);
        we = 1'b1; addr_w = 5'd3; data_w = 32'h33; step();
        we = 1'b0;
        rd(5'd3, 5'd4);
        check("sb_cnt1", 64'(busy_cnt), 64'd1);
        check("sb_busy_after_wb", 64'(busy_r), 64'b10);
        check("sb_r3_data", 64'(data_r[31:0]), 64'h33);

        // Issue and write the same address: issue wins, data lands.
        iss_valid = 1'b1; iss_addr = 5'd9; we = 1'b1; addr_w = 5'd9; data_w = 32'h99; step();
        iss_valid = 1'b0; we = 1'b0;
        rd(5'd9, 5'd0);
        check("same_cnt", 64'(busy_cnt), 64'd2);
        check("same_busy9", 64'(busy_r[0]), 64'd1);
        check("same_data9", 64'(data_r[31:0]), 64'h99);

        // Issue 10 while writing busy 11: count unchanged.
        iss_valid = 1'b1; iss_addr = 5'd11; step();
        check("pre_cnt3", 64'(busy_cnt), 64'd3);
        iss_addr = 5'd10; we = 1'b1; addr_w = 5'd11; data_w = 32'hB; step();
        iss_valid = 1'b0; we = 1'b0;
        rd(5'd10, 5'd11);
        check("swap_cnt", 64'(busy_cnt), 64'd3);
        check("swap_busy", 64'(busy_r), 64'b01);

        // Bypass: reg6 holds 0x66 and is busy; write 0xA5A5A5A5 while reading port 1.
        we = 1'b1; addr_w = 5'd6; data_w = 32'h66; step();
        we = 1'b0; iss_valid = 1'b1; iss_addr = 5'd6; step();
        iss_valid = 1'b0;
        check("byp_pre_cnt", 64'(busy_cnt), 64'd4);
        we = 1'b1; addr_w = 5'd6; data_w = 32'hA5A5A5A5;
        rd(5'd0, 5'd6);
`ifdef RF_BYPASS_EN
        check("byp_data", 64'(data_r[63:32]), 64'hA5A5A5A5);
        check("byp_busy", 64'(busy_r[1]), 64'd0);
`else
        check("nobyp_data", 64'(data_r[63:32]), 64'h66);
        check("nobyp_busy", 64'(busy_r[1]), 64'd1);
`endif
        step();
        we = 1'b0;
        rd(5'd0, 5'd6);
        check("post_wb_data", 64'(data_r[63:32]), 64'hA5A5A5A5);
        check("post_wb_busy", 64'(busy_r[1]), 64'd0);
        check("post_wb_cnt", 64'(busy_cnt), 64'd3);

        // Mid-operation reset discards pending state and restarts the sweep.
        rst = 1'b0; step();
        rst = 1'b1;
        check("mid_rst_cnt", 64'(busy_cnt), 64'd0);
        check("mid_rst_ready", 64'(ready), 64'd0);
        repeat (30) step();
        check("mid_sweep30", 64'(ready), 64'd0);
        step();
        check("mid_sweep31", 64'(ready), 64'd1);
        rd(5'd4, 5'd10);
        check("mid_busy_clear", 64'(busy_r), 64'b00);
        check("mid_cnt_clear", 64'(busy_cnt), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
